// File: rtl/trigger_link_rx.sv
// trigger_link_rx: receive end of one GEM trigger fiber.
// Rebuilds 4-word (64-bit) frames from the 16-bit decoded GTX stream.
// Hunts for frame alignment on the comma byte and tracks lock/unlock.
// Checks the periodic latency marker and keeps a saturating error count.
module trigger_link_rx #(
    parameter int          LOCK_FRAMES     = 8,
    parameter int          UNLOCK_ERRS     = 4,
    parameter int          MARKER_PERIOD   = 128,
    parameter int          ERR_CNT_WIDTH   = 16,
    parameter logic [13:0] INVALID_CLUSTER = 14'h3FFF
) (
    input  logic                     clk_160,
    input  logic                     reset_n,
    input  logic [15:0]              rx_data,
    input  logic [1:0]               rx_isk,
    input  logic [1:0]               rx_code_err,
    output logic [13:0]              cluster0,
    output logic [13:0]              cluster1,
    output logic [13:0]              cluster2,
    output logic [13:0]              cluster3,
    output logic                     overflow,
    output logic                     frame_valid,
    output logic                     bx0,
    output logic                     locked,
    output logic                     frame_err,
    output logic                     marker_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam int MW = $clog2(MARKER_PERIOD);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);
    localparam logic [MW-1:0] MCNT_LAST = MW'(MARKER_PERIOD - 1);

    // S_DROP is the single cycle after the last tolerated bad frame; the link
    // still reports locked there so the final error strobe is seen while locked.
    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_LOCKED = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    function automatic logic is_kchar(input logic [7:0] b);
        return (b == 8'hBC) || (b == 8'hF7) || (b == 8'hFC) || (b == 8'h3C);
    endfunction

    function automatic logic is_marker(input logic [7:0] b);
        return (b == 8'hFC) || (b == 8'h3C);
    endfunction

    function automatic logic is_overflow(input logic [7:0] b);
        return (b == 8'hF7) || (b == 8'h3C);
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t          state;
    logic [1:0]      wcnt;
    logic            in_frame;
    logic            bad_p0;
    logic [GW-1:0]   good_cnt;
    logic [BW-1:0]   bad_cnt;
    logic            armed;
    logic [MW-1:0]   mcnt;
    logic [7:0]      k_p0;
    logic [39:0]     data_p0;

    logic            comma_w;
    logic            w0_ok;
    logic            wn_ok;
    logic            take_w0;
    logic            frame_bad;
    logic            is_mrk;
    logic            mrk_err;
    logic [55:0]     frame_d;

    assign comma_w   = rx_isk[0] && is_kchar(rx_data[7:0]);
    assign w0_ok     = (rx_isk == 2'b01) && is_kchar(rx_data[7:0]) && (rx_code_err == 2'b00);
    assign wn_ok     = (rx_isk == 2'b00) && (rx_code_err == 2'b00);
    assign take_w0   = (state == S_SEARCH) ? comma_w : (wcnt == 2'd0);
    // Evaluated while w3 is on the input: w3 itself is never stored.
    assign frame_bad = bad_p0 || !wn_ok;
    assign is_mrk    = !frame_bad && is_marker(k_p0);
    assign mrk_err   = armed && (is_mrk ? (mcnt != MCNT_LAST) : (mcnt == MCNT_LAST));
    assign frame_d   = {rx_data, data_p0};

    // Stage p0: collect the K byte and data of w0..w2 for the frame in flight
    always_ff @(posedge clk_160) begin
        if (take_w0) begin
            k_p0          <= rx_data[7:0];
            data_p0[7:0]  <= rx_data[15:8];
        end else if (wcnt == 2'd1) begin
            data_p0[23:8] <= rx_data;
        end else if (wcnt == 2'd2) begin
            data_p0[39:24] <= rx_data;
        end
    end

    // Alignment/lock FSM, marker checking, error counting and registered outputs
    always_ff @(posedge clk_160 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_SEARCH;
            wcnt        <= 2'd0;
            in_frame    <= 1'b0;
            bad_p0      <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            armed       <= 1'b0;
            mcnt        <= '0;
            cluster0    <= INVALID_CLUSTER;
            cluster1    <= INVALID_CLUSTER;
            cluster2    <= INVALID_CLUSTER;
            cluster3    <= INVALID_CLUSTER;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
            bx0         <= 1'b0;
            locked      <= 1'b0;
            frame_err   <= 1'b0;
            marker_err  <= 1'b0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            marker_err  <= 1'b0;
            case (state)
                S_SEARCH: begin
                    if (comma_w) begin
                        // A comma in mid-frame means the frame in progress was bad.
                        if (in_frame && wcnt != 2'd0) good_cnt <= '0;
                        in_frame <= 1'b1;
                        wcnt     <= 2'd1;
                        bad_p0   <= !w0_ok;
                    end else if (in_frame) begin
                        if (wcnt == 2'd0) begin
                            in_frame <= 1'b0;
                            good_cnt <= '0;
                        end else if (wcnt == 2'd3) begin
                            wcnt <= 2'd0;
                            if (frame_bad) begin
                                good_cnt <= '0;
                                in_frame <= 1'b0;
                            end else if (good_cnt == GOOD_LAST) begin
                                state    <= S_LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                                armed    <= 1'b0;
                                mcnt     <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            wcnt   <= wcnt + 2'd1;
                            bad_p0 <= bad_p0 || !wn_ok;
                        end
                    end
                end
                S_LOCKED: begin
                    wcnt <= wcnt + 2'd1;
                    if (wcnt == 2'd0) begin
                        bad_p0 <= !w0_ok;
                    end else if (wcnt != 2'd3) begin
                        bad_p0 <= bad_p0 || !wn_ok;
                    end else begin
                        frame_valid <= 1'b1;
                        frame_err   <= frame_bad || mrk_err;
                        marker_err  <= mrk_err;
                        if (frame_bad || mrk_err) err_cnt <= sat_inc(err_cnt);
                        if (is_mrk) begin
                            armed <= 1'b1;
                            mcnt  <= '0;
                        end else begin
                            mcnt  <= mcnt + 1'b1;
                        end
                        if (frame_bad) begin
                            cluster0 <= INVALID_CLUSTER;
                            cluster1 <= INVALID_CLUSTER;
                            cluster2 <= INVALID_CLUSTER;
                            cluster3 <= INVALID_CLUSTER;
                            overflow <= 1'b0;
                            bx0      <= 1'b0;
                            bad_cnt  <= bad_cnt + 1'b1;
                            if (bad_cnt == BAD_LAST) state <= S_DROP;
                        end else begin
                            cluster0 <= frame_d[13:0];
                            cluster1 <= frame_d[27:14];
                            cluster2 <= frame_d[41:28];
                            cluster3 <= frame_d[55:42];
                            overflow <= is_overflow(k_p0);
                            bx0      <= is_marker(k_p0);
                            bad_cnt  <= '0;
                        end
                    end
                end
                S_DROP: begin
                    state    <= S_SEARCH;
                    locked   <= 1'b0;
                    in_frame <= 1'b0;
                    good_cnt <= '0;
                    armed    <= 1'b0;
                    wcnt     <= 2'd0;
                    overflow <= 1'b0;
                    bx0      <= 1'b0;
                end
                default: begin
                    state <= S_SEARCH;
                end
            endcase
        end
    end

endmodule
